usb_frame_loader: RTL and testbench

- Receive path from the USB byte interface toward the FFT core.
- Accepts a byte stream, packs every 4 bytes into one complex sample of 16-bit {re, im}, and stores FRAME_LEN samples in an internal single-port-per-side RAM.
- Once the frame is complete, streams it to the FFT as a gap-free burst of FRAME_LEN samples, then returns to loading.
- Single clock domain (CLK). The USB-side byte source is already synchronised to CLK upstream.

---
 rtl/usb_frame_loader.sv | 109 ++++++++++
 tb/tb_usb_frame_loader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/usb_frame_loader.sv
// USB receive-side frame loader: packs bytes into 16+16-bit complex samples,
// buffers one frame in RAM and replays it to the FFT as a gap-free burst.
module usb_frame_loader #(
  parameter int FRAME_LEN = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_rd,
  input  logic        fft_ready,
  output logic [15:0] sample_re,
  output logic [15:0] sample_im,
  output logic        sample_valid,
  output logic        frame_start,
  output logic        sample_last,
  output logic        busy,
  output logic [15:0] frame_count
);

  typedef enum logic [1:0] {LOAD, WAIT, STREAM} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

  state_t            state_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [ADDR_W-1:0] rd_addr_reg;
  logic [1:0]        byte_cnt_reg;
  logic [23:0]       pack_reg;
  logic [31:0]       mem [FRAME_LEN];

  logic accept;
  logic wr_en;
  logic rd_en;

  assign byte_rd = (state_reg == LOAD) && !reset;
  assign busy    = (state_reg != LOAD);
  assign accept  = byte_valid && byte_rd;
  assign wr_en   = accept && (byte_cnt_reg == 2'd3);
  assign rd_en   = (state_reg == STREAM) && !reset;

  // The 4th byte goes straight into RAM alongside the three already shifted in.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_addr_reg] <= {pack_reg, byte_in};
    end
  end

  // Registered RAM read doubles as the output sample register.
  always_ff @(posedge CLK) begin
    if (reset) begin
      sample_re <= 16'd0;
      sample_im <= 16'd0;
    end else if (rd_en) begin
      {sample_re, sample_im} <= mem[rd_addr_reg];
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_reg    <= LOAD;
      wr_addr_reg  <= '0;
      rd_addr_reg  <= '0;
      byte_cnt_reg <= 2'd0;
      pack_reg     <= 24'd0;
      sample_valid <= 1'b0;
      frame_start  <= 1'b0;
      sample_last  <= 1'b0;
      frame_count  <= 16'd0;
    end else begin
      sample_valid <= 1'b0;
      frame_start  <= 1'b0;
      sample_last  <= 1'b0;
      case (state_reg)
        LOAD: begin
          if (accept) begin
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            pack_reg     <= {pack_reg[15:0], byte_in};
          end
          if (wr_en) begin
            // FRAME_LEN is a power of two, so the increment wraps to 0 by itself.
            wr_addr_reg <= wr_addr_reg + ADDR_W'(1);
            if (wr_addr_reg == LAST_ADDR) begin
              state_reg <= WAIT;
            end
          end
        end
        WAIT: begin
          if (fft_ready) begin
            state_reg <= STREAM;
          end
        end
        STREAM: begin
          sample_valid <= 1'b1;
          frame_start  <= (rd_addr_reg == '0);
          sample_last  <= (rd_addr_reg == LAST_ADDR);
          rd_addr_reg  <= rd_addr_reg + ADDR_W'(1);
          if (rd_addr_reg == LAST_ADDR) begin
            state_reg   <= LOAD;
            frame_count <= frame_count + 16'd1;
          end
        end
        default: state_reg <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_frame_loader.sv
// Directed bench for usb_frame_loader: loads frames of sample k = {k, ~k}
// and checks burst timing, contents, flags, backpressure and reset aborts.
module tb_usb_frame_loader;

  localparam int FL = 1024;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;
  logic        fft_ready = 1'b0;
  logic        byte_rd;
  logic [15:0] sample_re;
  logic [15:0] sample_im;
  logic        sample_valid;
  logic        frame_start;
  logic        sample_last;
  logic        busy;
  logic [15:0] frame_count;

  int tests = 0;
  int fails = 0;

  usb_frame_loader #(.FRAME_LEN(FL), .ADDR_W(10)) dut (
    .CLK          (CLK),
    .reset        (reset),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_rd      (byte_rd),
    .fft_ready    (fft_ready),
    .sample_re    (sample_re),
    .sample_im    (sample_im),
    .sample_valid (sample_valid),
    .frame_start  (frame_start),
    .sample_last  (sample_last),
    .busy         (busy),
    .frame_count  (frame_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte b of the stream: sample k = b/4, order re[15:8], re[7:0], im[15:8], im[7:0].
  function automatic logic [7:0] byte_of(input int b);
    logic [15:0] k;
    logic [15:0] nk;
    k  = 16'(b >> 2);
    nk = ~k;
    case (b & 3)
      0:       return k[15:8];
      1:       return k[7:0];
      2:       return nk[15:8];
      default: return nk[7:0];
    endcase
  endfunction

  // Offers 4*FL bytes, optionally with random gaps; returns on the negedge
  // after the final byte transferred, with byte_valid dropped.
  task automatic load_frame(input bit gaps);
    int idx = 0;
    int guard = 0;
    while (idx < 4 * FL && guard < 40000) begin
      @(negedge CLK);
      guard++;
      byte_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      byte_in    = byte_of(idx);
      if (byte_valid && byte_rd) idx++;
    end
    check("load_bytes_accepted", 32'(idx), 32'(4 * FL));
    @(negedge CLK);
    byte_valid = 1'b0;
    check("full_byte_rd", 32'(byte_rd), 32'(0));
    check("full_busy", 32'(busy), 32'(1));
  endtask

  // Waits for the first valid sample, checks its latency, then every sample.
  task automatic burst(input int exp_lat, input logic [15:0] exp_count);
    int lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (!sample_valid && lat < 20);
    check("burst_latency", 32'(lat), 32'(exp_lat));
    for (int k = 0; k < FL; k++) begin
      if (k > 0) @(negedge CLK);
      check("sample_valid", 32'(sample_valid), 32'(1));
      check("sample_data", {sample_re, sample_im}, {16'(k), ~16'(k)});
      check("frame_start", 32'(frame_start), 32'(k == 0));
      check("sample_last", 32'(sample_last), 32'(k == FL - 1));
      check("burst_byte_rd", 32'(byte_rd), 32'(k == FL - 1));
    end
    check("last_frame_count", 32'(frame_count), 32'(exp_count));
    @(negedge CLK);
    check("post_valid", 32'(sample_valid), 32'(0));
    check("post_start", 32'(frame_start), 32'(0));
    check("post_last", 32'(sample_last), 32'(0));
    check("post_hold", {sample_re, sample_im}, {16'(FL - 1), ~16'(FL - 1)});
    check("post_busy", 32'(busy), 32'(0));
    check("post_frame_count", 32'(frame_count), 32'(exp_count));
  endtask

  initial begin
    // Reset and idle
    repeat (3) @(negedge CLK);
    check("rst_byte_rd", 32'(byte_rd), 32'(0));
    check("rst_valid", 32'(sample_valid), 32'(0));
    reset = 1'b0;
    @(negedge CLK);
    check("idle_byte_rd", 32'(byte_rd), 32'(1));
    check("idle_busy", 32'(busy), 32'(0));
    check("idle_valid", 32'(sample_valid), 32'(0));
    check("idle_frame_count", 32'(frame_count), 32'(0));
    check("idle_sample", {sample_re, sample_im}, 32'd0);

    // Continuous load with fft_ready already high
    fft_ready = 1'b1;
    load_frame(1'b0);
    burst(2, 16'd1);

    // Gappy load, same data
    load_frame(1'b1);
    burst(2, 16'd2);

    // FFT not ready: held frame, bytes offered but refused
    fft_ready = 1'b0;
    load_frame(1'b0);
    byte_valid = 1'b1;
    byte_in    = 8'h5A;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (i % 50 == 0) begin
        check("hold_busy", 32'(busy), 32'(1));
        check("hold_byte_rd", 32'(byte_rd), 32'(0));
        check("hold_valid", 32'(sample_valid), 32'(0));
      end
    end
    byte_valid = 1'b0;
    fft_ready  = 1'b1;
    burst(2, 16'd3);

    // Reset after a partial sample discards the partial bytes
    byte_valid = 1'b1;
    byte_in    = 8'hAA;
    @(negedge CLK);
    byte_in    = 8'hBB;
    @(negedge CLK);
    byte_valid = 1'b0;
    reset      = 1'b1;
    @(negedge CLK);
    reset      = 1'b0;
    check("rst_partial_count", 32'(frame_count), 32'(0));
    load_frame(1'b0);
    burst(2, 16'd1);

    // Reset in the middle of a burst
    load_frame(1'b0);
    begin
      int lat = 0;
      do begin
        @(negedge CLK);
        lat++;
      end while (!sample_valid && lat < 20);
      check("abort_latency", 32'(lat), 32'(2));
    end
    repeat (500) @(negedge CLK);
    check("abort_sample500", {sample_re, sample_im}, {16'd500, ~16'd500});
    reset = 1'b1;
    @(negedge CLK);
    check("abort_valid", 32'(sample_valid), 32'(0));
    check("abort_byte_rd", 32'(byte_rd), 32'(0));
    check("abort_frame_count", 32'(frame_count), 32'(0));
    reset = 1'b0;
    @(negedge CLK);
    check("abort_after_byte_rd", 32'(byte_rd), 32'(1));
    check("abort_after_busy", 32'(busy), 32'(0));
    check("abort_after_valid", 32'(sample_valid), 32'(0));
    load_frame(1'b0);
    burst(2, 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
